// File: rtl/ser_to_para_block_if.sv
// ser_to_para_block_if: beat input, clear and word output handshake bundle for ser_to_para_block
interface ser_to_para_block_if #(
  parameter int DIN_W  = 1,
  parameter int WORD_W = 128
);
  logic [DIN_W-1:0]  in;
  logic              en;
  logic              in_ready;
  logic              clr;
  logic [WORD_W-1:0] out;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              par_err;
  modport master (output in, en, clr, out_ready, input in_ready, out, out_valid, busy, par_err);
  modport slave  (input in, en, clr, out_ready, output in_ready, out, out_valid, busy, par_err);
endinterface

// File: rtl/ser_to_para_block.sv
// ser_to_para_block: serial-to-parallel word loader with bit order select, output backpressure and abort
// Optional SER2PAR_PARITY_EN appends an even-parity beat per word and reports mismatches on par_err.
module ser_to_para_block #(
  parameter int DIN_W     = 1,
  parameter int WORD_W    = 128,
  parameter bit MSB_FIRST = 0
) (
  input logic              clk,
  input logic              rst,
  ser_to_para_block_if.slave b
);
  localparam int BEATS = WORD_W / DIN_W;
`ifdef SER2PAR_PARITY_EN
  localparam int LAST = BEATS;
`else
  localparam int LAST = BEATS - 1;
`endif
  localparam int CW = LAST < 1 ? 1 : $clog2(LAST + 1);
  logic [CW-1:0]     cnt;
  logic [WORD_W-1:0] sh, sh_nx, word, out_q;
  logic              out_valid_q, last, take, done;
  assign last       = cnt == CW'(LAST);
  assign b.in_ready = !(last && out_valid_q && !b.out_ready);
  assign take       = b.en && b.in_ready && !b.clr;
  assign done       = take && last;
  assign b.busy     = cnt != '0;
  assign b.out      = out_q;
  assign b.out_valid = out_valid_q;
  generate
    if (BEATS == 1) begin : g_one
      assign sh_nx = b.in;
    end else if (MSB_FIRST) begin : g_msb
      assign sh_nx = {sh[WORD_W-DIN_W-1:0], b.in};
    end else begin : g_lsb
      assign sh_nx = {b.in, sh[WORD_W-1:DIN_W]};
    end
  endgenerate
`ifdef SER2PAR_PARITY_EN
  // The parity beat does not shift, so the word is already complete in sh.
  logic par_q;
  assign word      = sh;
  assign b.par_err = par_q;
  always_ff @(posedge clk)
    if (rst) par_q <= 1'b0;
    else if (done) par_q <= ^{sh, b.in[0]};
`else
  assign word      = sh_nx;
  assign b.par_err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      sh          <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (b.clr || done) begin
        cnt <= '0;
        sh  <= '0;
      end else if (take) begin
        cnt <= cnt + 1'b1;
        sh  <= sh_nx;
      end
      if (done) begin
        out_q       <= word;
        out_valid_q <= 1'b1;
      end else if (b.out_ready) out_valid_q <= 1'b0;
    end
  end
endmodule
